multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the CPU datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and generates the timing strobes the combinational control decode lacks: PC_WE, IR_WE, memory request/write and register-write enable.
- Waits on a memory ready handshake, supports HALT/resume and a memory watchdog.
- Sits beside Control_Unit: it gates Control_Unit's static decode in time.

Parameters:
- MEM_TIMEOUT, 64: max consecutive wait cycles on mem_ready in FETCH/MEM before ERROR; 0 disables the watchdog.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  4  instruction opcode from the IR; valid in DECODE.
- mem_ready  input  1  memory completes the current request this cycle.
- resume  input  1  leave HALT.
- mem_req  output  1  memory access request.
- mem_we  output  1  store qualifier (only with mem_req).
- IR_WE  output  1  instruction register write enable.
- PC_WE  output  1  program counter write enable.
- reg_wr_en  output  1  register file write strobe.
- branch_eval  output  1  datapath evaluates the branch/jump target this cycle.
- state  output  3  current state encoding.
- halted  output  1  in HALT.
- bus_error  output  1  watchdog fired; sticky until reset.
- retired  output  CNT_W  completed-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- State encoding: BOOT=7, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- Reset values: state=BOOT; all strobes 0; bus_error=0; retired=0; wait counter=0; op_q=0.
- Reset mid-instruction aborts it immediately; no strobe is emitted.
- BOOT: lasts 1 cycle, then FETCH.
- Opcode classes (op_q):
  - 0 = LOAD
  - 1 = STORE
  - 2..8 = ALU
  - 9..13 = BRANCH (beq, blt, bgt, ble, bge)
  - 14 = JUMP
  - 15 = HALT
- FETCH:
  - mem_req=1, mem_we=0.
  - IR_WE = mem_ready (Mealy). On mem_ready go to DECODE, else stay.
- DECODE:
  - op_q <= opcode.
  - HALT opcode goes to HALT; all others go to EXEC.
- EXEC:
  - branch_eval=1 for BRANCH/JUMP, with PC_WE=1 (PC_WE is the PC update; the datapath selects target vs PC+1); retire; then FETCH.
  - LOAD/STORE go to MEM; ALU goes to WB.
- MEM:
  - mem_req=1; mem_we=1 for STORE only.
  - Waits for mem_ready.
  - On mem_ready, STORE: PC_WE=1 (Mealy), retire, go to FETCH.
  - On mem_ready, LOAD: go to WB.
- WB: reg_wr_en=1, PC_WE=1, retire, then FETCH.
- HALT:
  - halted=1; no strobes while resume=0.
  - resume=1: PC_WE=1 (steps past HALT), go to FETCH. The resume pulse does not increment retired.
- Minimum latency with mem_ready tied high: ALU 4, LOAD 5, STORE 4, BRANCH/JUMP 3 cycles.
- Exactly one PC_WE pulse per instruction; IR_WE exactly once per FETCH.
- Watchdog:
  - The counter clears on entering FETCH/MEM and on mem_ready; it increments each FETCH/MEM cycle with mem_ready=0.
  - When it reaches MEM_TIMEOUT, go to ERROR and set bus_error=1.
  - mem_ready in the same cycle as the threshold wins (normal completion).
- ERROR: all strobes 0; held until reset; resume is ignored.
- resume outside HALT is ignored. mem_ready outside FETCH/MEM is ignored.
- retired increments on the same edge as each retiring PC_WE.

Test Plan:
- mem_ready=1, opcodes ALU(2), LOAD(0), STORE(1), BEQ(9):
  - states 0,1,2,4 / 0,1,2,3,4 / 0,1,2,3 / 0,1,2.
  - Exactly 4 PC_WE pulses; retired=4; reg_wr_en only for ALU and LOAD.
- FETCH with mem_ready held low 3 cycles then high:
  - mem_req high 4 cycles; IR_WE only on the 4th; DECODE next.
- HALT(15):
  - halted=1, no strobes for 10 cycles.
  - resume pulse → PC_WE once, FETCH next; retired unchanged.
- MEM_TIMEOUT=4, STORE with mem_ready never asserted in MEM:
  - ERROR after 4 wait cycles; bus_error=1 persists; resume has no effect; reset clears it.
- Same config, mem_ready asserted exactly on the 4th wait cycle:
  - normal completion, no ERROR.
- Assert reset during MEM of a LOAD:
  - all outputs 0 immediately; BOOT, then FETCH after release.
- CNT_W=4, 16 JUMP(14) instructions:
  - retired wraps 15→0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_sequencer_if: opcode/memory handshake and strobe bundle        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface multicycle_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             mem_ready;
    logic             resume;
    logic             mem_req;
    logic             mem_we;
    logic             IR_WE;
    logic             PC_WE;
    logic             reg_wr_en;
    logic             branch_eval;
    logic [2:0]       state;
    logic             halted;
    logic             bus_error;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready, resume,
        output mem_req, mem_we, IR_WE, PC_WE, reg_wr_en, branch_eval,
               state, halted, bus_error, retired
    );

    modport slave (
        output opcode, mem_ready, resume,
        input  mem_req, mem_we, IR_WE, PC_WE, reg_wr_en, branch_eval,
               state, halted, bus_error, retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB timing strobe generator    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    multicycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6,
        S_BOOT   = 3'd7
    } state_t;

    // The counter never needs to hold MEM_TIMEOUT itself: reaching it leaves FETCH/MEM.
    localparam int WDT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [CNT_W-1:0] retired_q;
    logic             bus_error_q, bus_error_d;

    logic mem_req, mem_we, ir_we, pc_we, reg_wr_en, branch_eval, halted, retire;
    logic is_load, is_store, is_ctrl, wdt_expire;

    assign is_load    = (op_q == 4'd0);
    assign is_store   = (op_q == 4'd1);
    assign is_ctrl    = (op_q >= 4'd9) && (op_q <= 4'd14);
    assign wdt_expire = (MEM_TIMEOUT != 0) && (wdt_q == WDT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_BOOT;
            op_q        <= 4'd0;
            wdt_q       <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wdt_q       <= wdt_d;
            retired_q   <= retired_q + CNT_W'(retire);
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdt_d       = '0;
        bus_error_d = bus_error_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_wr_en   = 1'b0;
        branch_eval = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_BOOT: state_d = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wdt_expire) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
            end

            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = (bus.opcode == 4'd15) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                if (is_ctrl) begin
                    branch_eval = 1'b1;
                    pc_we       = 1'b1;
                    retire      = 1'b1;
                    state_d     = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wdt_expire) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
            end

            S_WB: begin
                reg_wr_en = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            // The resume step advances PC past the HALT but does not count as a retirement.
            S_HALT: begin
                halted = 1'b1;
                if (bus.resume) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_ERROR: state_d = S_ERROR;

            default: state_d = S_BOOT;
        endcase
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.IR_WE       = ir_we;
    assign bus.PC_WE       = pc_we;
    assign bus.reg_wr_en   = reg_wr_en;
    assign bus.branch_eval = branch_eval;
    assign bus.state       = state_q;
    assign bus.halted      = halted;
    assign bus.bus_error   = bus_error_q;
    assign bus.retired     = retired_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_sequencer: directed + randomized bench with a step-list model|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_multicycle_sequencer;
    localparam int MT = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.CNT_W(CW)) bus ();

    multicycle_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: mode 0=boot 1=running 2=halted 3=error; a running instruction is a list of
    // remaining phases (0 fetch,1 decode,2 exec,3 mem,4 wb), fixed by its opcode class.
    int m_mode;
    int m_steps[$];
    int m_op;
    int m_wait;
    int m_retired;

    logic [14:0] obs;
    logic [14:0] q_obs[$];

    function automatic bit is_ctrl(int op);
        return (op >= 9) && (op <= 14);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_steps = {}; m_op = 0; m_wait = 0; m_retired = 0;
    endtask

    task automatic model_expect(output logic [14:0] e, output bit ret);
        logic [2:0] st;
        bit mreq, mwe, ir, pc, rw, br, hl, be;
        mreq = 0; mwe = 0; ir = 0; pc = 0; rw = 0; br = 0; hl = 0; be = 0; st = 3'd7;
        case (m_mode)
            0: st = 3'd7;
            2: begin st = 3'd5; hl = 1; pc = bus.resume; end
            3: begin st = 3'd6; be = 1; end
            default: begin
                st = 3'(m_steps[0]);
                case (m_steps[0])
                    0: begin mreq = 1; ir = bus.mem_ready; end
                    2: if (is_ctrl(m_op)) begin br = 1; pc = 1; end
                    3: begin mreq = 1; mwe = (m_op == 1); pc = (m_op == 1) && bus.mem_ready; end
                    4: begin rw = 1; pc = 1; end
                    default: ;
                endcase
            end
        endcase
        ret = pc && (m_mode == 1);
        e = {st, mreq, mwe, ir, pc, rw, br, hl, be, 4'(m_retired)};
    endtask

    task automatic model_step();
        logic [14:0] e;
        bit ret;
        int cur;
        model_expect(e, ret);
        if (ret) m_retired++;
        case (m_mode)
            0: begin m_mode = 1; m_steps = {0}; m_wait = 0; end
            2: if (bus.resume) begin m_mode = 1; m_steps = {0}; m_wait = 0; end
            3: ;
            default: begin
                cur = m_steps[0];
                if (cur == 0 || cur == 3) begin
                    if (bus.mem_ready) begin
                        m_wait = 0;
                        void'(m_steps.pop_front());
                        if (cur == 0) m_steps.push_back(1);
                    end else begin
                        m_wait++;
                        if (MT != 0 && m_wait == MT) m_mode = 3;
                    end
                end else if (cur == 1) begin
                    m_op = int'(bus.opcode);
                    void'(m_steps.pop_front());
                    if (m_op == 15)     m_mode = 2;
                    else if (m_op == 0) m_steps = {2, 3, 4};
                    else if (m_op == 1) m_steps = {2, 3};
                    else if (m_op <= 8) m_steps = {2, 4};
                    else                m_steps = {2};
                end else begin
                    void'(m_steps.pop_front());
                end
                if (m_mode == 1 && m_steps.size() == 0) begin
                    m_steps = {0};
                    m_wait  = 0;
                end
            end
        endcase
    endtask

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycle(bit rdy, bit res, logic [3:0] op, bit rst);
        logic [14:0] e;
        bit ret;
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.resume    = res;
        bus.opcode    = op;
        reset         = rst;
        if (rst) model_reset();
        #1;
        model_expect(e, ret);
        obs = {bus.state, bus.mem_req, bus.mem_we, bus.IR_WE, bus.PC_WE, bus.reg_wr_en,
               bus.branch_eval, bus.halted, bus.bus_error, bus.retired};
        q_obs.push_back(obs);
        n_total++;
        if (obs !== e)
            $display("FAIL outputs t=%0t got {st,req,we,ir,pc,rw,br,hlt,err,ret}=%b expected %b",
                     $time, obs, e);
        else n_pass++;
        @(posedge clk);
        if (!rst) model_step();
    endtask

    function automatic int count_bit(int b);
        int n = 0;
        foreach (q_obs[i]) n += int'(q_obs[i][b]);
        return n;
    endfunction

    initial begin
        int exp_tr[17] = '{7, 0, 1, 2, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 0, 1, 2};
        int ops[4]     = '{2, 0, 1, 9};
        int lens[4]    = '{4, 5, 4, 3};
        int strobes;
        bus.mem_ready = 1'b0; bus.resume = 1'b0; bus.opcode = 4'd0;
        model_reset();

        cycle(0, 0, 4'd0, 1);
        chk("reset_state", int'(obs[14:12]), 7);
        chk("reset_retired", int'(obs[3:0]), 0);
        chk("reset_strobes", int'(obs[11:4]), 0);

        // ALU, LOAD, STORE, BEQ back to back with memory always ready
        q_obs = {};
        cycle(1, 0, 4'd0, 0);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < lens[k]; c++) cycle(1, 0, 4'(ops[k]), 0);
        for (int i = 0; i < 17; i++) chk($sformatf("trace[%0d]", i), int'(q_obs[i][14:12]), exp_tr[i]);
        chk("pc_we_pulses", count_bit(8), 4);
        chk("reg_wr_pulses", count_bit(7), 2);

        // FETCH stalled three cycles
        q_obs = {};
        for (int i = 0; i < 4; i++) cycle(i == 3, 0, 4'd15, 0);
        chk("retired_after_4", int'(q_obs[0][3:0]), 4);
        chk("fetch_mem_req", count_bit(11), 4);
        chk("fetch_ir_we_cnt", count_bit(9), 1);
        chk("fetch_ir_we_last", int'(q_obs[3][9]), 1);
        cycle(1, 0, 4'd15, 0);
        chk("decode_after_fetch", int'(obs[14:12]), 1);

        // HALT: quiet until resume
        q_obs = {};
        for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 0, 4'd0, 0);
        strobes = 0;
        foreach (q_obs[i]) strobes += int'(q_obs[i][11:6] != 0) + int'(q_obs[i][14:12] != 3'd5);
        chk("halt_quiet", strobes, 0);
        chk("halted_flag", count_bit(5), 10);
        cycle(0, 1, 4'd0, 0);
        chk("resume_pc_we", int'(obs[8]), 1);
        cycle(1, 0, 4'd1, 0);
        chk("fetch_after_resume", int'(obs[14:12]), 0);
        chk("retired_after_halt", int'(obs[3:0]), 4);

        // STORE whose MEM phase never completes
        cycle(1, 0, 4'd1, 0);
        cycle(1, 0, 4'd1, 0);
        q_obs = {};
        for (int i = 0; i < 4; i++) cycle(0, 0, 4'd1, 0);
        chk("mem_we_cycles", count_bit(10), 4);
        cycle(0, 1, 4'd1, 0);
        chk("error_state", int'(obs[14:12]), 6);
        chk("bus_error_set", int'(obs[4]), 1);
        cycle(1, 1, 4'd1, 0);
        chk("error_ignores_resume", int'(obs[14:12]), 6);
        chk("error_retired", int'(obs[3:0]), 4);
        cycle(0, 0, 4'd0, 1);
        chk("reset_clears_error", int'(obs[4]), 0);
        chk("reset_clears_retired", int'(obs[3:0]), 0);

        // STORE whose ready arrives on the threshold cycle
        for (int i = 0; i < 4; i++) cycle(1, 0, 4'd1, 0);
        for (int i = 0; i < 4; i++) cycle(i == 3, 0, 4'd1, 0);
        chk("threshold_ready_pc_we", int'(obs[8]), 1);
        cycle(1, 0, 4'd0, 0);
        chk("threshold_no_error", int'(obs[4]), 0);
        chk("threshold_state", int'(obs[14:12]), 0);
        chk("threshold_retired", int'(obs[3:0]), 1);

        // LOAD aborted by reset during MEM
        cycle(1, 0, 4'd0, 0);
        cycle(1, 0, 4'd0, 0);
        cycle(0, 0, 4'd0, 0);
        chk("load_in_mem", int'(obs[14:12]), 3);
        cycle(0, 0, 4'd0, 1);
        chk("abort_state", int'(obs[14:12]), 7);
        chk("abort_outputs", int'(obs[11:0]), 0);
        cycle(1, 0, 4'd14, 0);
        chk("boot_after_release", int'(obs[14:12]), 7);

        // 16 JUMPs: counter wraps
        q_obs = {};
        for (int j = 0; j < 16; j++) begin
            cycle(1, 0, 4'd14, 0);
            if (j == 0) chk("fetch_after_boot", int'(obs[14:12]), 0);
            if (j == 15) chk("retired_15", int'(obs[3:0]), 15);
            cycle(1, 0, 4'd14, 0);
            cycle(1, 0, 4'd14, 0);
        end
        chk("jump_pc_we", count_bit(8), 16);
        chk("jump_branch_eval", count_bit(6), 16);
        cycle(1, 0, 4'd2, 0);
        chk("retired_wrapped", int'(obs[3:0]), 0);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 299) == 0) || (m_mode == 3 && $urandom_range(0, 7) == 0);
            cycle($urandom_range(0, 99) < 75, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)), rst);
            q_obs = {};
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
